i2s_dac_tx: RTL and testbench

I2S_DAC_TX -- requirements
Module: i2s_dac_tx

---
 rtl/i2s_dac_tx_if.sv | 10 +
 rtl/i2s_dac_tx.sv | 175 +++++++++++++++++
 tb/tb_i2s_dac_tx.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_dac_tx_if.sv
// Frame write bus for i2s_dac_tx: one stereo frame per accepted write.
interface i2s_dac_tx_if #(parameter int W = 24);
  logic         write;
  logic [W-1:0] writedata_left;
  logic [W-1:0] writedata_right;
  logic         write_ready;

  modport master (output write, writedata_left, writedata_right, input write_ready);
  modport slave  (input write, writedata_left, writedata_right, output write_ready);
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: stereo frame FIFO feeding a serializer that is clocked
// by the codec's BCLK/LRCK, both resynchronized into the CLOCK_50 domain.
// Optional feature: define I2S_DAC_UNDERFLOW_EN to get a sticky underflow port.
module i2s_dac_tx #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  i2s_dac_tx_if.slave wr,
  input  logic       AUD_BCLK,
  input  logic       AUD_DACLRCK,
  output logic       AUD_DACDAT
`ifdef I2S_DAC_UNDERFLOW_EN
  ,
  output logic       underflow
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;

  // codec clock synchronizers and edge detection
  logic [1:0] bclk_sync_q, bclk_sync_d;
  logic [1:0] lrck_sync_q, lrck_sync_d;
  logic       bclk_prev_q, bclk_prev_d;
  logic       lrck_prev_q, lrck_prev_d;

  // frame FIFO
  logic [2*W-1:0] mem_q [DEPTH];
  logic [2*W-1:0] frame_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;

  // serializer
  state_t         state_q, state_d;
  logic [W-1:0]   hold_r_q, hold_r_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           dat_q, dat_d;

  logic           bclk_fe, lrck, word_start, fifo_empty, push, pop, underflow_evt;
  logic [2*W-1:0] rd_frame;

  assign lrck          = lrck_sync_q[1];
  assign bclk_fe       = bclk_prev_q & ~bclk_sync_q[1];
  assign word_start    = bclk_fe && (lrck != lrck_prev_q);
  assign fifo_empty    = (count_q == '0);
  // full check uses the pre-pop count, so a pop in the same cycle never frees a slot early
  assign wr.write_ready = !reset && (count_q != CW'(DEPTH));
  assign push          = wr.write && wr.write_ready;
  assign pop           = word_start && !lrck && !fifo_empty;
  assign underflow_evt = word_start && !lrck && fifo_empty;
  assign rd_frame      = mem_q[rptr_q];
  assign AUD_DACDAT    = dat_q;

  // synchronizer shifts, edge history and FIFO bookkeeping
  always_comb begin
    bclk_sync_d = {bclk_sync_q[0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[0], AUD_DACLRCK};
    bclk_prev_d = bclk_sync_q[1];
    lrck_prev_d = bclk_fe ? lrck : lrck_prev_q;
    frame_d     = {wr.writedata_left, wr.writedata_right};
    wptr_d      = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d      = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // serializer: word start wins in any state, then one delay slot, then W bits MSB first
  always_comb begin
    state_d   = state_q;
    hold_r_d  = hold_r_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    dat_d     = dat_q;
    if (word_start) begin
      state_d   = DELAY;
      dat_d     = 1'b0;
      bit_cnt_d = '0;
      if (!lrck) begin
        if (fifo_empty) begin
          shreg_d  = '0;
          hold_r_d = '0;
        end else begin
          shreg_d  = rd_frame[2*W-1:W];
          hold_r_d = rd_frame[W-1:0];
        end
      end else begin
        shreg_d = hold_r_q;
      end
    end else if (bclk_fe) begin
      case (state_q)
        IDLE: dat_d = 1'b0;
        DELAY: begin
          state_d   = SHIFT;
          dat_d     = shreg_q[W-1];
          shreg_d   = {shreg_q[W-2:0], 1'b0};
          bit_cnt_d = BW'(1);
        end
        SHIFT: begin
          if (bit_cnt_q == BW'(W)) begin
            state_d = IDLE;
            dat_d   = 1'b0;
          end else begin
            dat_d     = shreg_q[W-1];
            shreg_d   = {shreg_q[W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state registers, all cleared by reset
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      hold_r_q    <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      dat_q       <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_prev_q <= lrck_prev_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hold_r_q    <= hold_r_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      dat_q       <= dat_d;
    end
  end

  // FIFO storage; contents are don't-care while count is 0
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wptr_q] <= frame_d;
  end

`ifdef I2S_DAC_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // sticky underflow: any left-word start on an empty FIFO
  always_comb begin
    underflow_d = underflow_q | underflow_evt;
  end

  // underflow register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) underflow_q <= 1'b0;
    else       underflow_q <= underflow_d;
  end

  assign underflow = underflow_q;
`else
  logic unused_uf;
  assign unused_uf = underflow_evt;
`endif
endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx. The codec clocks are generated here and
// a slot-level model predicts the bit the codec would sample on each BCLK rise.
module tb_i2s_dac_tx;
  localparam int W     = 24;
  localparam int DEPTH = 8;

  logic CLOCK_50    = 1'b0;
  logic reset       = 1'b1;
  logic AUD_BCLK    = 1'b0;
  logic AUD_DACLRCK = 1'b0;
  logic AUD_DACDAT;
`ifdef I2S_DAC_UNDERFLOW_EN
  logic underflow;
`endif

  i2s_dac_tx_if #(.W(W)) wr_if ();

  i2s_dac_tx #(.DEPTH(DEPTH), .W(W)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .wr         (wr_if),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK),
    .AUD_DACDAT (AUD_DACDAT)
`ifdef I2S_DAC_UNDERFLOW_EN
    ,
    .underflow  (underflow)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  // codec clock generator state: BCLK = CLOCK_50/16, LRCK toggles every 32 BCLK falls
  bit bclk_en = 1'b0;
  int div     = 0;
  int bits    = 28;

  // reference model: queue of accepted frames and the current word/slot on the wire
  logic [2*W-1:0] m_q[$];
  logic           m_prev = 1'b0;
  int             m_slot = W + 1;
  logic [W-1:0]   m_word = '0;
  logic [W-1:0]   m_hold = '0;
  bit             m_ws   = 1'b0;
  logic           exp_bit = 1'b0;
  event           fall_ev, rise_ev;

  function automatic void model_fall();
    logic [2*W-1:0] f;
    m_ws = (AUD_DACLRCK != m_prev);
    if (m_ws) begin
      if (!AUD_DACLRCK) begin
        if (m_q.size() > 0) f = m_q.pop_front();
        else                f = '0;
        m_word = f[2*W-1:W];
        m_hold = f[W-1:0];
      end else begin
        m_word = m_hold;
      end
      m_slot = 0;
    end else if (m_slot <= W) begin
      m_slot++;
    end
    m_prev = AUD_DACLRCK;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prev = 1'b0;
    m_slot = W + 1;
    m_word = '0;
    m_hold = '0;
  endtask

  always @(negedge CLOCK_50) begin
    if (bclk_en) begin
      div++;
      if (div == 8) begin
        div = 0;
        AUD_BCLK = ~AUD_BCLK;
        if (!AUD_BCLK) begin
          bits++;
          if (bits == 32) begin
            bits = 0;
            AUD_DACLRCK = ~AUD_DACLRCK;
          end
          model_fall();
          -> fall_ev;
        end else begin
          exp_bit = (m_slot >= 1 && m_slot <= W) ? m_word[W - m_slot] : 1'b0;
          -> rise_ev;
        end
      end
    end
  end

  // one-cycle write starting on a CLOCK_50 negedge; model accepts when it holds fewer than DEPTH
  task automatic drive_push(input logic [W-1:0] l, input logic [W-1:0] r);
    bit rdy;
    rdy = (m_q.size() != DEPTH);
    wr_if.write           = 1'b1;
    wr_if.writedata_left  = l;
    wr_if.writedata_right = r;
    @(negedge CLOCK_50);
    wr_if.write = 1'b0;
    if (rdy) m_q.push_back({l, r});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (wr_if.write_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wr_if.write_ready); end
    checks++;
    if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL reset_dat: got %b want 0", AUD_DACDAT); end
`ifdef I2S_DAC_UNDERFLOW_EN
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b want 0", underflow); end
`endif
    reset = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (wr_if.write_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", wr_if.write_ready); end
  endtask

  task automatic test_single_frame();
    logic [W-1:0] cap_l, cap_r;
    int nl, nr;
    cap_l = '0; cap_r = '0; nl = 0; nr = 0;
    drive_push(24'hA5A5A5, 24'h123456);
    bclk_en = 1'b1;
    repeat (110) begin
      @(rise_ev);
      checks++;
      if (AUD_DACDAT !== exp_bit) begin errors++; $display("FAIL single_bit slot %0d: got %b want %b", m_slot, AUD_DACDAT, exp_bit); end
      if (m_slot >= 1 && m_slot <= W) begin
        if (!AUD_DACLRCK && nl < W) begin cap_l = {cap_l[W-2:0], AUD_DACDAT}; nl++; end
        else if (AUD_DACLRCK && nl == W && nr < W) begin cap_r = {cap_r[W-2:0], AUD_DACDAT}; nr++; end
      end
    end
    bclk_en = 1'b0;
    checks++;
    if (cap_l !== 24'hA5A5A5) begin errors++; $display("FAIL single_left: got %h want a5a5a5", cap_l); end
    checks++;
    if (cap_r !== 24'h123456) begin errors++; $display("FAIL single_right: got %h want 123456", cap_r); end
  endtask

  task automatic test_fill();
    @(negedge CLOCK_50);
    for (int i = 0; i < DEPTH + 1; i++) begin
      checks++;
      if (wr_if.write_ready !== (m_q.size() != DEPTH)) begin
        errors++; $display("FAIL fill_ready push %0d: got %b want %b", i, wr_if.write_ready, (m_q.size() != DEPTH));
      end
      drive_push(W'($urandom), W'($urandom));
    end
    checks++;
    if (wr_if.write_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", wr_if.write_ready); end
  endtask

  task automatic test_pop_at_full();
    bit found;
    found = 1'b0;
    bclk_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(fall_ev);
      if (m_ws && !AUD_DACLRCK) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL popfull_wait: got no left word start want one"); end
    // the pop lands on the third CLOCK_50 rise after the BCLK fall; write is held across exactly that edge
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (wr_if.write_ready !== 1'b0) begin errors++; $display("FAIL popfull_before: got %b want 0", wr_if.write_ready); end
    wr_if.write           = 1'b1;
    wr_if.writedata_left  = 24'hDEADBE;
    wr_if.writedata_right = 24'hEFCAFE;
    @(negedge CLOCK_50);
    wr_if.write = 1'b0;
    checks++;
    if (wr_if.write_ready !== 1'b1) begin errors++; $display("FAIL popfull_after: got %b want 1", wr_if.write_ready); end
  endtask

  task automatic test_stream();
    int pushed;
    pushed = 0;
    repeat (1150) begin
      @(rise_ev);
      checks++;
      if (AUD_DACDAT !== exp_bit) begin errors++; $display("FAIL stream_bit slot %0d: got %b want %b", m_slot, AUD_DACDAT, exp_bit); end
      if (pushed < 9 && m_q.size() < DEPTH) begin
        checks++;
        if (wr_if.write_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b want 1", wr_if.write_ready); end
        drive_push(W'($urandom), W'($urandom));
        pushed++;
      end
    end
  endtask

  task automatic test_underflow();
    repeat (140) begin
      @(rise_ev);
      checks++;
      if (AUD_DACDAT !== exp_bit) begin errors++; $display("FAIL under_bit slot %0d: got %b want %b", m_slot, AUD_DACDAT, exp_bit); end
    end
`ifdef I2S_DAC_UNDERFLOW_EN
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL under_flag: got %b want 1", underflow); end
`endif
  endtask

  task automatic test_reset_mid_word();
    bit found;
    found = 1'b0;
    @(rise_ev);
    drive_push(24'hFFFFFF, 24'h0F0F0F);
    drive_push(24'h5A5A5A, 24'h3C3C3C);
`ifdef I2S_DAC_UNDERFLOW_EN
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL under_held: got %b want 1", underflow); end
`endif
    for (int i = 0; i < 300; i++) begin
      @(rise_ev);
      checks++;
      if (AUD_DACDAT !== exp_bit) begin errors++; $display("FAIL midword_bit slot %0d: got %b want %b", m_slot, AUD_DACDAT, exp_bit); end
      if (!AUD_DACLRCK && m_slot == 11 && m_word == 24'hFFFFFF) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midword_wait: got no bit 10 want one"); end
    bclk_en = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL midreset_dat: got %b want 0", AUD_DACDAT); end
    checks++;
    if (wr_if.write_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b want 0", wr_if.write_ready); end
`ifdef I2S_DAC_UNDERFLOW_EN
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL midreset_uf: got %b want 0", underflow); end
`endif
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    // an empty FIFO after release accepts exactly DEPTH frames
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (wr_if.write_ready !== 1'b1) begin errors++; $display("FAIL postreset_ready push %0d: got %b want 1", i, wr_if.write_ready); end
      drive_push(W'($urandom), W'($urandom));
    end
    checks++;
    if (wr_if.write_ready !== 1'b0) begin errors++; $display("FAIL postreset_full: got %b want 0", wr_if.write_ready); end
    bclk_en = 1'b1;
    repeat (200) begin
      @(rise_ev);
      checks++;
      if (AUD_DACDAT !== exp_bit) begin errors++; $display("FAIL postreset_bit slot %0d: got %b want %b", m_slot, AUD_DACDAT, exp_bit); end
    end
    bclk_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_if.write           = 1'b0;
    wr_if.writedata_left  = '0;
    wr_if.writedata_right = '0;
    test_reset();
    test_single_frame();
    test_fill();
    test_pop_at_full();
    test_stream();
    test_underflow();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
